// File: rtl/tagged_req_issue.sv
// Tag consumer behind id_tracker: binds upstream requests to free tags, issues them to memory,
// and matches out-of-order tagged responses back to their stored request metadata.

module tagged_req_entry #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  set,
    input  logic                  clr,
    input  logic [ID_WIDTH-1:0]   set_id,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    output logic                  pending,
    output logic [ID_WIDTH-1:0]   id,
    output logic [ADDR_WIDTH-1:0] addr
);

    // Set beats clear so a tag retired and immediately re-offered stays pending.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pending <= 1'b0;
        else if (set)
            pending <= 1'b1;
        else if (clr)
            pending <= 1'b0;
    end

    // Metadata is meaningless until pending is set, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (set) begin
            id   <= set_id;
            addr <= set_addr;
        end
    end

endmodule

module tagged_req_issue #(
    parameter int TAG_COUNT  = 4,
    parameter int TAG_WIDTH  = $clog2(TAG_COUNT),
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  new_tag_consume,
    input  logic                  new_tag_ready,
    input  logic [TAG_WIDTH-1:0]  new_tag,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [TAG_WIDTH-1:0]  mem_resp_tag,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  old_tag_done,
    output logic [TAG_WIDTH-1:0]  old_tag,
    output logic [TAG_WIDTH:0]    outstanding_count,
    output logic                  spurious_resp
);

    logic                  accept;
    logic                  capture;
    logic                  hit;
    logic                  retire;
    logic [TAG_WIDTH-1:0]  resp_tag_r;
    logic [TAG_COUNT-1:0]  pending;
    logic [ID_WIDTH-1:0]   ent_id   [TAG_COUNT];
    logic [ADDR_WIDTH-1:0] ent_addr [TAG_COUNT];

    assign req_ready       = new_tag_ready & (~mem_req_valid | mem_req_ready);
    assign accept          = req_valid & req_ready;
    assign new_tag_consume = accept;

    assign mem_resp_ready  = ~resp_valid | resp_ready;
    assign capture         = mem_resp_valid & mem_resp_ready;
    assign hit             = capture & pending[mem_resp_tag];

    assign retire          = resp_valid & resp_ready;
    assign old_tag_done    = retire;
    assign old_tag         = resp_tag_r;

    genvar g;
    generate
        for (g = 0; g < TAG_COUNT; g++) begin : g_ent
            tagged_req_entry #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .ID_WIDTH   (ID_WIDTH)
            ) u_ent (
                .CLK      (CLK),
                .nRST     (nRST),
                .set      (accept && (new_tag == TAG_WIDTH'(g))),
                .clr      (retire && (resp_tag_r == TAG_WIDTH'(g))),
                .set_id   (req_id),
                .set_addr (req_addr),
                .pending  (pending[g]),
                .id       (ent_id[g]),
                .addr     (ent_addr[g])
            );
        end
    endgenerate

    // Count is derived from the pending vector so it can never drift past TAG_COUNT.
    always_comb begin
        outstanding_count = '0;
        for (int i = 0; i < TAG_COUNT; i++)
            outstanding_count = outstanding_count + {{TAG_WIDTH{1'b0}}, pending[i]};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_tag   <= '0;
        end else if (accept) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= req_addr;
            mem_req_tag   <= new_tag;
        end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_addr     <= '0;
            resp_data     <= '0;
            resp_tag_r    <= '0;
            spurious_resp <= 1'b0;
        end else begin
            spurious_resp <= capture & ~hit;
            if (hit) begin
                resp_valid <= 1'b1;
                resp_id    <= ent_id[mem_resp_tag];
                resp_addr  <= ent_addr[mem_resp_tag];
                resp_data  <= mem_resp_data;
                resp_tag_r <= mem_resp_tag;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // A tag handed out while still pending means id_tracker lost track of it.
    always_ff @(posedge CLK) begin
        if (nRST && accept)
            assert (!pending[new_tag])
            else $error("tagged_req_issue: tag %0d accepted while pending", new_tag);
    end
`endif

endmodule

// File: tb/tb_tagged_req_issue.sv
// Directed bench for tagged_req_issue with a cycle model and request/response scoreboards.

module tb_tagged_req_issue;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_id;
    logic        new_tag_consume;
    logic        new_tag_ready;
    logic [1:0]  new_tag;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_tag;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [1:0]  mem_resp_tag;
    logic [31:0] mem_resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_id;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic        old_tag_done;
    logic [1:0]  old_tag;
    logic [2:0]  outstanding_count;
    logic        spurious_resp;

    tagged_req_issue dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_id            (req_id),
        .new_tag_consume   (new_tag_consume),
        .new_tag_ready     (new_tag_ready),
        .new_tag           (new_tag),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_ready    (mem_resp_ready),
        .mem_resp_tag      (mem_resp_tag),
        .mem_resp_data     (mem_resp_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_id           (resp_id),
        .resp_addr         (resp_addr),
        .resp_data         (resp_data),
        .old_tag_done      (old_tag_done),
        .old_tag           (old_tag),
        .outstanding_count (outstanding_count),
        .spurious_resp     (spurious_resp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tag;
    } mreq_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  tag;
    } rexp_t;

    int    total = 0;
    int    bad   = 0;
    int    retires = 0;
    mreq_t mq[$];
    rexp_t rq[$];

    bit [3:0]  pend;
    bit        m_mv, m_rv, m_spur;
    bit [3:0]  tbl_id   [4];
    bit [31:0] tbl_addr [4];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Samples 2ns after each falling edge: inputs are settled, next rising edge is 3ns away.
    always @(negedge CLK) begin : mon
        bit    exp_rr, exp_mrr, acc, cap, hit, ret;
        mreq_t m;
        rexp_t e;
        #2;
        if (!nRST) begin
            check("rst_count", outstanding_count, 0);
            check("rst_mem_req_valid", mem_req_valid, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_spurious", spurious_resp, 0);
            check("rst_old_tag_done", old_tag_done, 0);
            pend = '0; m_mv = 0; m_rv = 0; m_spur = 0;
            mq.delete(); rq.delete();
        end else begin
            exp_rr  = new_tag_ready && (!m_mv || mem_req_ready);
            exp_mrr = !m_rv || resp_ready;
            acc     = req_valid && exp_rr;
            cap     = mem_resp_valid && exp_mrr;
            hit     = cap && pend[mem_resp_tag];
            ret     = m_rv && resp_ready;
            check("req_ready", req_ready, exp_rr);
            check("new_tag_consume", new_tag_consume, acc);
            check("mem_resp_ready", mem_resp_ready, exp_mrr);
            check("mem_req_valid", mem_req_valid, m_mv);
            check("resp_valid", resp_valid, m_rv);
            check("spurious_resp", spurious_resp, m_spur);
            check("old_tag_done", old_tag_done, ret);
            check("outstanding_count", outstanding_count, $countones(pend));
            if (m_mv && mem_req_ready) begin
                check("mreq_q_nonempty", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    m = mq.pop_front();
                    check("mem_req_addr", mem_req_addr, m.addr);
                    check("mem_req_tag", mem_req_tag, m.tag);
                end
            end
            if (ret) begin
                check("resp_q_nonempty", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_addr", resp_addr, e.addr);
                    check("resp_data", resp_data, e.data);
                    check("old_tag", old_tag, e.tag);
                    pend[e.tag] = 1'b0;
                    retires++;
                end
            end
            if (hit)
                rq.push_back('{tbl_id[mem_resp_tag], tbl_addr[mem_resp_tag], mem_resp_data, mem_resp_tag});
            if (acc) begin
                tbl_id[new_tag]   = req_id;
                tbl_addr[new_tag] = req_addr;
                pend[new_tag]     = 1'b1;
                mq.push_back('{req_addr, new_tag});
            end
            m_mv   = acc ? 1'b1 : (mem_req_ready ? 1'b0 : m_mv);
            m_rv   = hit ? 1'b1 : (resp_ready ? 1'b0 : m_rv);
            m_spur = cap && !hit;
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [3:0] id, input logic [1:0] t);
        req_valid = 1'b1; req_addr = a; req_id = id; new_tag = t;
    endtask

    task automatic drive_resp(input logic [1:0] t, input logic [31:0] d);
        mem_resp_valid = 1'b1; mem_resp_tag = t; mem_resp_data = d;
    endtask

    initial begin
        int r0;
        logic [1:0] order [4];
        nRST = 1'b0;
        req_valid = 0; req_addr = '0; req_id = '0; new_tag_ready = 0; new_tag = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
        resp_ready = 0;
        repeat (2) cyc();
        nRST = 1'b1;
        cyc();

        // 1: single request binds tag 2
        new_tag_ready = 1; mem_req_ready = 1; resp_ready = 1;
        drive_req(32'h100, 4'd3, 2'd2);
        #1 check("s1_consume", new_tag_consume, 1);
        cyc(); req_valid = 0;
        #1 check("s1_mem_req_valid", mem_req_valid, 1);
        check("s1_mem_req_addr", mem_req_addr, 32'h100);
        check("s1_mem_req_tag", mem_req_tag, 2);
        check("s1_count", outstanding_count, 1);

        // 2: response for tag 2
        cyc(); drive_resp(2'd2, 32'hCAFE);
        cyc(); mem_resp_valid = 0;
        #1 check("s2_resp_valid", resp_valid, 1);
        check("s2_resp_id", resp_id, 3);
        check("s2_resp_addr", resp_addr, 32'h100);
        check("s2_resp_data", resp_data, 32'hCAFE);
        check("s2_old_tag_done", old_tag_done, 1);
        check("s2_old_tag", old_tag, 2);
        cyc();
        #1 check("s2_count", outstanding_count, 0);

        // 3: fill all tags, then out-of-order responses
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h200 + 32'(i * 16), 4'(8 + i), 2'(i));
            cyc();
        end
        new_tag_ready = 0;
        #1 check("s3_count_full", outstanding_count, 4);
        check("s3_req_ready", req_ready, 0);
        check("s3_consume", new_tag_consume, 0);
        cyc(); req_valid = 0;
        r0 = retires;
        order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            drive_resp(order[i], 32'hD000 + 32'(order[i]));
            cyc();
        end
        mem_resp_valid = 0;
        repeat (2) cyc();
        #1 check("s3_retires", retires - r0, 4);
        check("s3_count_empty", outstanding_count, 0);

        // 4: memory backpressure stalls the second request
        new_tag_ready = 1; mem_req_ready = 0;
        drive_req(32'h300, 4'd5, 2'd0);
        cyc(); drive_req(32'h304, 4'd6, 2'd1);
        for (int i = 0; i < 3; i++) begin
            #1 check("s4_req_ready_stall", req_ready, 0);
            check("s4_mem_req_addr_hold", mem_req_addr, 32'h300);
            check("s4_mem_req_tag_hold", mem_req_tag, 0);
            cyc();
        end
        mem_req_ready = 1;
        #1 check("s4_consume_drain", new_tag_consume, 1);
        cyc(); req_valid = 0;
        #1 check("s4_mem_req_addr2", mem_req_addr, 32'h304);
        check("s4_mem_req_tag2", mem_req_tag, 1);

        // 5: upstream backpressure on responses
        cyc(); resp_ready = 0; drive_resp(2'd0, 32'hA0);
        cyc(); drive_resp(2'd1, 32'hA1);
        for (int i = 0; i < 2; i++) begin
            #1 check("s5_mem_resp_ready", mem_resp_ready, 0);
            check("s5_no_retire", old_tag_done, 0);
            check("s5_resp_data_hold", resp_data, 32'hA0);
            cyc();
        end
        resp_ready = 1;
        #1 check("s5_retire0", old_tag_done, 1);
        check("s5_old_tag0", old_tag, 0);
        cyc(); mem_resp_valid = 0;
        #1 check("s5_resp_valid1", resp_valid, 1);
        check("s5_resp_data1", resp_data, 32'hA1);
        check("s5_old_tag1", old_tag, 1);
        cyc();
        #1 check("s5_count", outstanding_count, 0);

        // 6: spurious response, then reset with requests in flight
        drive_resp(2'd1, 32'hBAD);
        cyc(); mem_resp_valid = 0;
        #1 check("s6_spurious", spurious_resp, 1);
        check("s6_no_resp", resp_valid, 0);
        cyc();
        #1 check("s6_spurious_clear", spurious_resp, 0);
        drive_req(32'h400, 4'd1, 2'd2);
        cyc(); drive_req(32'h404, 4'd2, 2'd3);
        cyc(); req_valid = 0; mem_req_ready = 0;
        #1 check("s6_count_pending", outstanding_count, 2);
        cyc(); nRST = 1'b0;
        #1 check("s6_rst_count", outstanding_count, 0);
        check("s6_rst_mem_req_valid", mem_req_valid, 0);
        check("s6_rst_resp_valid", resp_valid, 0);
        check("s6_rst_old_tag_done", old_tag_done, 0);
        cyc(); nRST = 1'b1; mem_req_ready = 1;
        repeat (2) cyc();
        #1 check("s6_post_count", outstanding_count, 0);
        check("end_mreq_q_empty", mq.size(), 0);
        check("end_resp_q_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
